// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;

    // Widest packed request bus the slice helper accepts; callers zero-extend to it.
    localparam int PK_MAXW = 1024;

    function automatic logic [63:0] get_slice(input logic [PK_MAXW-1:0] bus,
                                              input int idx, input int w);
        return 64'(bus >> (idx * w));
    endfunction

endpackage

// File: rtl/BusDriver.sv
// rtl/BusDriver.sv - tri-state driver for a shared data bus
module BusDriver #(
    parameter int DW = 16
) (
    input  logic          en,
    input  logic [DW-1:0] din,
    inout  tri   [DW-1:0] bus
);

    assign bus = en ? din : 'z;

endmodule

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner search starting at ptr
module rr_picker #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   win
);

    logic [NREQ-1:0] rot;

    // Rotating the doubled vector puts requester ptr at bit 0, so the lowest set bit wins.
    always_comb begin
        rot = NREQ'({req, req} >> ptr);
        any = |req;
        win = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) win = PW'((int'(ptr) + j) % NREQ);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sequencing requesters onto one single-port memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int AW   = 8
) (
    input  logic              clock,
    input  logic              reset_L,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [DW-1:0]     rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    inout  tri   [DW-1:0]     mem_data
);

    localparam int PW = $clog2(NREQ);

    arb_state_t     state, state_nx;
    logic [PW-1:0]  ptr, win_q, pick_win;
    logic           pick_any, we_q;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .win (pick_win)
    );

    always_ff @(posedge clock, negedge reset_L) begin
        if (!reset_L) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_any) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Fields are latched at the grant so later requester changes cannot disturb the access.
    always_ff @(posedge clock, negedge reset_L) begin
        if (!reset_L) begin
            ptr     <= '0;
            win_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                win_q   <= pick_win;
                we_q    <= req_we[pick_win];
                addr_q  <= AW'(get_slice(PK_MAXW'(req_addr), int'(pick_win), AW));
                wdata_q <= DW'(get_slice(PK_MAXW'(req_wdata), int'(pick_win), DW));
                ptr     <= PW'((int'(pick_win) + 1) % NREQ);
            end
            if (state == ACCESS && !we_q) rdata <= mem_data;
        end
    end

    always_comb begin
        gnt    = '0;
        done   = '0;
        mem_re = 1'b0;
        mem_we = 1'b0;
        case (state)
            ACCESS: begin
                gnt[win_q] = 1'b1;
                mem_we     = we_q;
                mem_re     = !we_q;
            end
            RESP:    done[win_q] = 1'b1;
            default: ;
        endcase
    end

    assign mem_addr = addr_q;

    BusDriver #(.DW(DW)) u_bus (
        .en  (state == ACCESS && we_q),
        .din (wdata_q),
        .bus (mem_data)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a transaction-level model
module tb_mem_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int AW   = 8;
    localparam logic [31:0] ZZ = 32'h0000zzzz;

    logic              clock = 1'b0;
    logic              reset_L = 1'b0;
    logic [NREQ-1:0]   req, req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]   gnt, done;
    logic [DW-1:0]     rdata;
    logic              mem_re, mem_we;
    logic [AW-1:0]     mem_addr;
    tri   [DW-1:0]     mem_data;

    logic [DW-1:0] mem_arr [0:255];
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] m_rdata;
    int            mptr;
    int            order[$];
    int            n_checks = 0;
    int            n_errors = 0;

    mem_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data)
    );

    assign mem_data = mem_re ? mem_arr[mem_addr] : 'z;
    always @(posedge clock) if (mem_we) mem_arr[mem_addr] <= mem_data;

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]             = 1'b1;
        req_we[i]          = we;
        req_addr[i*AW+:AW]  = a;
        req_wdata[i*DW+:DW] = d;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_gnt"},   32'(gnt),    32'd0);
        chk({tag, "_done"},  32'(done),   32'd0);
        chk({tag, "_re"},    32'(mem_re), 32'd0);
        chk({tag, "_we"},    32'(mem_we), 32'd0);
        chk({tag, "_bus"},   32'(mem_data), ZZ);
        chk({tag, "_rdata"}, 32'(rdata),  32'(m_rdata));
    endtask

    task automatic check_reset_vals(input string tag);
        check_quiet(tag);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    endtask

    // One arbitration: called #1 after an edge with the DUT idle; returns #1 after the next idle edge.
    task automatic serve(input bit drop, input int late);
        int w;
        logic we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        w = pick(req, mptr);
        if (w < 0) begin
            @(posedge clock); #1;
            check_quiet("idle");
            return;
        end
        we = req_we[w];
        a  = req_addr[w*AW+:AW];
        d  = req_wdata[w*DW+:DW];
        mptr = (w + 1) % NREQ;
        order.push_back(w);
        @(posedge clock); #1;
        chk("acc_gnt",  32'(gnt),    32'(1 << w));
        chk("acc_done", 32'(done),   32'd0);
        chk("acc_we",   32'(mem_we), 32'(we));
        chk("acc_re",   32'(mem_re), 32'(!we));
        chk("acc_addr", 32'(mem_addr), 32'(a));
        chk("acc_data", 32'(mem_data), we ? 32'(d) : 32'(ref_mem[a]));
        if (late >= 0) req[late] = 1'b1;
        @(posedge clock); #1;
        if (we) ref_mem[a] = d;
        else    m_rdata = ref_mem[a];
        chk("resp_done",  32'(done),   32'(1 << w));
        chk("resp_gnt",   32'(gnt),    32'd0);
        chk("resp_re",    32'(mem_re), 32'd0);
        chk("resp_we",    32'(mem_we), 32'd0);
        chk("resp_bus",   32'(mem_data), ZZ);
        chk("resp_rdata", 32'(rdata),  32'(m_rdata));
        if (drop) req[w] = 1'b0;
        @(posedge clock); #1;
        check_quiet("post");
    endtask

    initial begin
        req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        m_rdata = '0;
        mptr = 0;
        #12;
        check_reset_vals("reset");
        @(negedge clock) reset_L = 1'b1;
        @(posedge clock); #1;

        // All four requesters at once: writes to addresses 0..3, granted in index order.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i), DW'($urandom));
        for (int i = 0; i < NREQ; i++) serve(1'b1, -1);
        for (int i = 0; i < NREQ; i++) chk("simul_order", 32'(order[i]), 32'(i));
        for (int i = 4; i < 8; i++) begin
            set_req(0, 1'b1, AW'(i), DW'($urandom));
            serve(1'b1, -1);
        end

        set_req(1, 1'b1, 8'h10, 16'hBEEF);
        serve(1'b1, -1);
        set_req(2, 1'b0, 8'h10, 16'h0000);
        serve(1'b1, -1);
        chk("wr_rd_rdata", 32'(rdata), 32'h0000BEEF);

        // Bring ptr to 0, then hold 0 and 3 continuously.
        set_req(3, 1'b0, 8'h01, 16'h0);
        serve(1'b1, -1);
        order.delete();
        set_req(0, 1'b0, 8'h02, 16'h0);
        set_req(3, 1'b0, 8'h03, 16'h0);
        for (int i = 0; i < 4; i++) serve(1'b0, -1);
        for (int i = 0; i < 4; i++) chk("fair_order", 32'(order[i]), (i % 2 == 0) ? 32'd0 : 32'd3);
        req[0] = 1'b0;
        order.delete();
        for (int i = 0; i < 3; i++) serve(1'b0, -1);
        for (int i = 0; i < 3; i++) chk("solo3_order", 32'(order[i]), 32'd3);
        req[3] = 1'b0;

        // Requester 2 raises its request while requester 3 is in ACCESS.
        set_req(3, 1'b0, 8'h04, 16'h0);
        req_we[2] = 1'b1; req_addr[2*AW+:AW] = 8'h30; req_wdata[2*DW+:DW] = 16'h5555;
        order.delete();
        serve(1'b1, 2);
        serve(1'b1, -1);
        chk("late_order0", 32'(order[0]), 32'd3);
        chk("late_order1", 32'(order[1]), 32'd2);

        // Reset during a write access must not commit the write.
        set_req(0, 1'b1, 8'h20, 16'h1111);
        serve(1'b1, -1);
        set_req(0, 1'b1, 8'h20, 16'h2222);
        @(posedge clock); #1;
        chk("rst_pre_we", 32'(mem_we), 32'd1);
        #2 reset_L = 1'b0;
        #1;
        m_rdata = '0;
        check_reset_vals("rst_mid");
        req = '0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clock); #1;
            chk("rst_no_done", 32'(done), 32'd0);
        end
        @(negedge clock) reset_L = 1'b1;
        mptr = 0;
        @(posedge clock); #1;
        check_quiet("rst_after");
        set_req(1, 1'b0, 8'h20, 16'h0);
        serve(1'b1, -1);
        chk("rst_rd_rdata", 32'(rdata), 32'h00001111);

        for (int it = 0; it < 80; it++) begin
            for (int i = 0; i < NREQ; i++)
                if (!req[i] && $urandom_range(0, 2) != 0)
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
            serve($urandom_range(0, 3) != 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter and sequencer that shares one single-port `Memory` (re/we, shared tri-state data bus) among `NREQ` requesters. It accepts one request at a time and drives the memory's `re`, `we`, `addr` and `data` lines for exactly one cycle. It then returns read data with a one-cycle `done` pulse to the winning requester. It sits between the datapath clients (fetch, load/store, DMA) and the memory instance.

## Interface
- `NREQ`, 4: number of requesters (≥2).
- `DW`, 16: data width; must match the `Memory` DW.
- `AW`, 8: address width; must match the `Memory` AW.
- `clock` input, 1 bit: rising-edge clock.
- `reset_L` input, 1 bit: reset; asynchronous, active-low.
- `req` input, NREQ bits: request per requester. Held high, with `req_we`/`req_addr`/`req_wdata` stable, until `done[i]`.
- `req_we` input, NREQ bits: 1 = write, 0 = read, per requester.
- `req_addr` input, NREQ*AW bits: packed addresses; requester i is at `[i*AW +: AW]`.
- `req_wdata` input, NREQ*DW bits: packed write data; requester i is at `[i*DW +: DW]`.
- `gnt` output, NREQ bits: one-hot; winner's bit is high during ACCESS.
- `done` output, NREQ bits: one-hot, one-cycle pulse in RESP.
- `rdata` output, DW bits: read data, valid while `done` is high; holds its value otherwise.
- `mem_re` output, 1 bit: to `Memory.re`.
- `mem_we` output, 1 bit: to `Memory.we`.
- `mem_addr` output, AW bits: to `Memory.addr`.
- `mem_data` inout tri, DW bits: to `Memory.data`.

## Operation
- FSM states:
  - **IDLE**: if any `req` is high, pick a winner round-robin starting at `ptr`. Latch its index, we, addr and wdata. Set `ptr <= winner+1` (mod NREQ). Go to ACCESS. If no `req` is high, stay in IDLE.
  - **ACCESS**: `gnt[win]=1` and `mem_addr`=latched addr.
    - Write: `mem_we=1`, and `mem_data` is driven with the latched wdata.
    - Read: `mem_re=1`, and `rdata` captures `mem_data` at the clock edge ending ACCESS.
    - Go to RESP.
  - **RESP**: `done[win]=1`. Go to IDLE unconditionally.
- `mem_we`, `mem_re`, `gnt` and `done` are decoded from the state register only, with no input-to-output paths.
- The arbiter drives `mem_data` only in ACCESS with we=1; it is `'z` at all other times. Exactly one of `mem_re`/`mem_we` is high in ACCESS; both are 0 in every other state.
- Round-robin rule:
  - The search order is `ptr, ptr+1, …, NREQ-1, 0, …`, wrapping modulo NREQ.
  - A continuously asserted requester waits at most NREQ-1 other grants.
- A requester that keeps `req` high after its `done` is treated as a new transaction, arbitrated in the next IDLE.
- Requests that arrive during ACCESS or RESP are ignored until IDLE. Changes to a request's fields after the latch have no effect.
- Reset values (asynchronous): state=IDLE, `ptr=0`, latched fields=0, `rdata=0`, `gnt=0`, `done=0`, `mem_re=0`, `mem_we=0`, `mem_addr=0`, `mem_data='z`.
- Reset mid-operation: asserting reset during ACCESS drops `mem_we` immediately, so no write commits. The pending transaction is discarded with no `done`, and the requester must re-request.

## Timing
- A request sampled high at edge e0 (in IDLE) gives ACCESS in cycle e0→e1 and RESP/`done` in cycle e1→e2. The request may be deasserted at e2.
- The minimum spacing between transactions is 3 cycles, so peak throughput is one access per 3 cycles.
- The memory write commits at e1, and read data is registered into `rdata` at e1.
- Idle-to-grant latency is 1 edge. The worst-case wait under full load is 3*NREQ cycles.

## Structure
- Package `mem_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t`.
  - Helper function for packed-slice extraction.
- Sub-module `rr_picker #(NREQ)`:
  - Combinational.
  - Inputs: `req`, `ptr`. Outputs: `any`, `win` (`$clog2(NREQ)` bits).
  - Internally uses a double-width rotate-and-priority scheme.
- `mem_data` is driven through a `BusDriver` instance, with `en = (state==ACCESS) && we_q`.
- State, `ptr`, latched fields and `rdata` use `always_ff @(posedge clock, negedge reset_L)`.

## Test plan
- **Single write then read**:
  - `req[1]`, we=1, addr=0x10, wdata=0xBEEF → `gnt=4'b0010` and `mem_we=1` for one cycle, then `done[1]`.
  - Then `req[2]` reads 0x10 → `mem_re=1` for one cycle, and `rdata=0xBEEF` with `done[2]`.
- **Simultaneous requests**: all four `req` high right after reset → grant order 0,1,2,3, `done` at cycles 2, 5, 8, 11, with no duplicate grants.
- **Fairness and wrap**:
  - `req[0]` and `req[3]` held continuously → grants alternate 0,3,0,3 and `ptr` wraps to 0 after 3.
  - `req[3]` alone → granted every 3 cycles.
- **Bus hygiene**: across a mixed read/write stream, check `mem_data`=`'z` whenever not (ACCESS and write). `mem_re` and `mem_we` are never both high and are never high outside ACCESS.
- **Reset mid-write**:
  - Preload 0x20=0x1111, then issue a write of 0x2222 to 0x20.
  - Assert `reset_L=0` mid-ACCESS → all outputs take their reset values immediately.
  - A later read of 0x20 returns 0x1111, and no `done` is seen for the aborted transaction.
- **Late request**: `req[2]` rises during another requester's ACCESS → it is not granted until the next IDLE, then receives `done` 2 cycles later.
